// File: rtl/stump_mem_responder.sv
// Stump memory-side responder: word RAM plus an I/O page (TX FIFO, status, cycle counter).
// Optional CYCLES register at 0xFFF2 is built only when STUMP_MEM_CYCLE_COUNTER_EN is defined.
module stump_mem_responder #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] address,
    input  logic [15:0] data_in,
    input  logic        mem_ren,
    input  logic        mem_wen,
    output logic [15:0] data_out,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        fifo_full
);

    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned RAM_WORDS = 1 << ADDR_W;

    localparam logic [15:0] TXDATA_ADDR = 16'hFFF0;
    localparam logic [15:0] STATUS_ADDR = 16'hFFF1;
    localparam logic [15:0] CYCLES_ADDR = 16'hFFF2;

    logic [15:0] ram [RAM_WORDS];
    logic [15:0] fifo_mem [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             full_q;
    logic             overflow;

    logic        is_ram;
    logic        sel_tx;
    logic        sel_status;
    logic        sel_cycles;
    logic        rd_en;
    logic        push_req;
    logic        push;
    logic        pop;
    logic        ovf_set;
    logic        ovf_clr;
    logic [15:0] status_word;
    logic [15:0] cycles_rd;

    // Address decode and FIFO handshake qualification
    always_comb begin
        is_ram     = 32'(address) < RAM_WORDS;
        sel_tx     = address == TXDATA_ADDR;
        sel_status = address == STATUS_ADDR;
        sel_cycles = address == CYCLES_ADDR;
        rd_en      = mem_ren & ~mem_wen;
        push_req   = mem_wen & sel_tx;
        pop        = (count != '0) & out_ready;
        push       = push_req & (~full_q | pop);
        ovf_set    = push_req & full_q & ~pop;
        ovf_clr    = mem_wen & sel_status & data_in[2];
        count_next = count + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (mem_wen && is_ram && !rst)
            ram[address[ADDR_W-1:0]] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (push && !rst)
            fifo_mem[wr_ptr] <= data_in;
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full_q   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count  <= count_next;
            full_q <= count_next == CNT_W'(FIFO_DEPTH);
            if (ovf_set)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

`ifdef STUMP_MEM_CYCLE_COUNTER_EN
    logic [15:0] cycles;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cycles <= 16'h0000;
        else if (mem_wen && sel_cycles)
            cycles <= data_in;
        else
            cycles <= cycles + 16'd1;
    end

    assign cycles_rd = cycles;
`else
    assign cycles_rd = 16'h0000;
`endif

    assign status_word = {8'h00, 4'(count), 1'b0, overflow, full_q, count == '0};

    // Zero-latency read mux; simultaneous write suppresses the read
    always_comb begin
        data_out = 16'h0000;
        if (rd_en) begin
            if (is_ram)
                data_out = ram[address[ADDR_W-1:0]];
            else if (sel_status)
                data_out = status_word;
            else if (sel_cycles)
                data_out = cycles_rd;
        end
    end

    assign out_valid = count != '0;
    assign out_data  = out_valid ? fifo_mem[rd_ptr] : 16'h0000;
    assign fifo_full = full_q;

endmodule

// File: tb/tb_stump_mem_responder.sv
// Self-checking bench for stump_mem_responder: directed test-plan steps plus random traffic
// checked against a queue-based reference model.
module tb_stump_mem_responder;

    localparam int DEPTH = 4;
`ifdef STUMP_MEM_CYCLE_COUNTER_EN
    localparam bit CYC_EN = 1'b1;
`else
    localparam bit CYC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] address;
    logic [15:0] data_in;
    logic        mem_ren;
    logic        mem_wen;
    logic [15:0] data_out;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        fifo_full;

    stump_mem_responder #(.ADDR_W(8), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .address   (address),
        .data_in   (data_in),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .data_out  (data_out),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fifo_full (fifo_full)
    );

    always #5 clk = ~clk;

    int unsigned total  = 0;
    int unsigned passed = 0;
    int unsigned failed = 0;

    // Reference model state
    logic [15:0] ram_m [256];
    bit          ram_v [256];
    logic [15:0] q [$];
    bit          ovf_m;
    logic [15:0] cyc_m;

    logic [15:0] last_dout;
    logic [15:0] last_odata;
    logic        last_ovalid;
    logic        last_full;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] status_m();
        return {8'h00, 4'(q.size()), 1'b0, ovf_m, q.size() == DEPTH, q.size() == 0};
    endfunction

    // One bus cycle: drive at negedge, check mid-cycle, then advance the model past the posedge
    task automatic cycle(input logic [15:0] a, input logic [15:0] d,
                         input logic ren, input logic wen, input logic rdy);
        bit          known;
        bit          pop;
        bit          full;
        logic [15:0] exp_rd;
        @(negedge clk);
        address   = a;
        data_in   = d;
        mem_ren   = ren;
        mem_wen   = wen;
        out_ready = rdy;
        #1;
        last_dout   = data_out;
        last_odata  = out_data;
        last_ovalid = out_valid;
        last_full   = fifo_full;
        known  = 1'b1;
        exp_rd = 16'h0000;
        if (ren && !wen) begin
            if (a < 16'h0100) begin
                known  = ram_v[a[7:0]];
                exp_rd = ram_m[a[7:0]];
            end else if (a == 16'hFFF1) begin
                exp_rd = status_m();
            end else if (a == 16'hFFF2) begin
                exp_rd = CYC_EN ? cyc_m : 16'h0000;
            end
        end
        if (known)
            chk("data_out", data_out, exp_rd);
        chk("out_valid", 16'(out_valid), 16'(q.size() != 0));
        chk("out_data", out_data, (q.size() != 0) ? q[0] : 16'h0000);
        chk("fifo_full", 16'(fifo_full), 16'(q.size() == DEPTH));
        @(posedge clk);
        pop  = (q.size() != 0) && rdy;
        full = q.size() == DEPTH;
        if (wen && a < 16'h0100) begin
            ram_m[a[7:0]] = d;
            ram_v[a[7:0]] = 1'b1;
        end
        if (wen && a == 16'hFFF1 && d[2])
            ovf_m = 1'b0;
        if (pop)
            void'(q.pop_front());
        if (wen && a == 16'hFFF0) begin
            if (full && !pop)
                ovf_m = 1'b1;
            else
                q.push_back(d);
        end
        if (wen && a == 16'hFFF2)
            cyc_m = d;
        else
            cyc_m = cyc_m + 16'd1;
    endtask

    // Idle inputs, hold reset over two edges, release just after a negedge
    task automatic do_reset();
        address   = 16'h0000;
        data_in   = 16'h0000;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        ovf_m = 1'b0;
        // one idle edge passes before the next driven cycle
        cyc_m = 16'd1;
    endtask

    task automatic push(input logic [15:0] d, input logic rdy);
        cycle(16'hFFF0, d, 1'b0, 1'b1, rdy);
    endtask

    task automatic read_status();
        cycle(16'hFFF1, 16'h0000, 1'b1, 1'b0, 1'b0);
    endtask

    logic [15:0] seq_a [4] = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
    logic [15:0] seq_b [4] = '{16'hA002, 16'hA003, 16'hA004, 16'hC0DE};

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram_v[i] = 1'b0;
            ram_m[i] = 16'h0000;
        end
        ovf_m = 1'b0;
        cyc_m = 16'h0000;
        do_reset();

        // Reset state
        read_status();
        chk("reset_status", last_dout, 16'h0001);
        chk("reset_odata", last_odata, 16'h0000);

        // RAM access
        cycle(16'h0005, 16'h1234, 1'b0, 1'b1, 1'b0);
        cycle(16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("ram_read", last_dout, 16'h1234);
        cycle(16'h0006, 16'h0000, 1'b0, 1'b0, 1'b0);
        chk("ren_low", last_dout, 16'h0000);
        cycle(16'h0005, 16'h5555, 1'b1, 1'b1, 1'b0);
        chk("ren_wen_both", last_dout, 16'h0000);
        cycle(16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("ram_overwrite", last_dout, 16'h5555);
        cycle(16'h0100, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("unmapped_read", last_dout, 16'h0000);

        // FIFO fill then drain
        for (int i = 0; i < 4; i++) push(seq_a[i], 1'b0);
        read_status();
        chk("status_full", last_dout, 16'h0042);
        chk("full_flag", 16'(last_full), 16'h0001);
        for (int i = 0; i < 4; i++) begin
            cycle(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
            chk("drain_seq", last_odata, seq_a[i]);
        end
        read_status();
        chk("status_empty", last_dout, 16'h0001);
        chk("drained_valid", 16'(last_ovalid), 16'h0000);

        // Overflow set and clear
        for (int i = 0; i < 4; i++) push(seq_a[i], 1'b0);
        push(16'hBEEF, 1'b0);
        read_status();
        chk("status_ovf", last_dout, 16'h0046);
        cycle(16'hFFF1, 16'h0004, 1'b0, 1'b1, 1'b0);
        read_status();
        chk("status_ovf_clr", last_dout, 16'h0042);

        // Full with simultaneous push and pop
        push(16'hC0DE, 1'b1);
        read_status();
        chk("status_pushpop", last_dout, 16'h0042);
        for (int i = 0; i < 4; i++) begin
            cycle(16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
            chk("drain_seq2", last_odata, seq_b[i]);
        end
        read_status();
        chk("status_empty2", last_dout, 16'h0001);

        // Cycle counter load and wrap
        cycle(16'hFFF2, 16'hFFFE, 1'b0, 1'b1, 1'b0);
        cycle(16'hFFF2, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("cyc0", last_dout, CYC_EN ? 16'hFFFE : 16'h0000);
        cycle(16'hFFF2, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("cyc1", last_dout, CYC_EN ? 16'hFFFF : 16'h0000);
        cycle(16'hFFF2, 16'h0000, 1'b1, 1'b0, 1'b0);
        chk("cyc2", last_dout, 16'h0000);

        // Async reset with two words queued and a push in flight
        push(16'h1111, 1'b0);
        push(16'h2222, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_valid", 16'(out_valid), 16'h0000);
        chk("async_odata", out_data, 16'h0000);
        do_reset();
        read_status();
        chk("post_reset_status", last_dout, 16'h0001);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            logic [15:0] a;
            int unsigned r;
            r = $urandom_range(0, 9);
            if (r <= 4)      a = 16'($urandom_range(0, 15));
            else if (r == 5) a = ($urandom_range(0, 1) == 0) ? 16'h00FF : 16'h0100;
            else if (r <= 7) a = 16'hFFF0;
            else if (r == 8) a = 16'hFFF1;
            else             a = ($urandom_range(0, 1) == 0) ? 16'hFFF2 : 16'(16'h8000 | $urandom_range(0, 255));
            cycle(a, 16'($urandom), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
